hs32_fetch: RTL

//  Instruction fetch sequencer for hs32_pipeline. Issues word reads to instruction

---
 rtl/hs32_pkg.sv | 16 +
 rtl/hs32_fifo.sv | 60 ++++++
 rtl/hs32_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hs32_pkg.sv
// Shared types and constants for the hs32 fetch path.
package hs32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] op;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/hs32_fifo.sv
// Prefetch FIFO: register-based storage, head visible combinationally, one-cycle flush.
module hs32_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [63:0]
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  entry_t                       data_i,
    input  logic                         pop_i,
    output entry_t                       data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = ($clog2(DEPTH+1))'(wr_ptr_q - rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/hs32_fetch.sv
// Instruction fetch sequencer: credit-limited word reads, prefetch FIFO, redirect
// with stale-response discard.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] op_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;   // next address to place on the bus
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;     // address of the next live response
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            stale_req_q, stale_req_d;

    logic            gnt_fire, drop_resp, credit_ok;
    logic            out_inc, out_dec, dis_inc, dis_dec;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   fifo_count_next, slots_used;
    logic [XLEN-1:0] issue_pc;
    fetch_entry_t    push_entry, head_entry;

    assign valid_o  = ~fifo_empty & ~redirect_i;
    assign fifo_pop = valid_o & ready_i;

    always_comb begin
        gnt_fire   = req_q & mem_gnt_i;
        drop_resp  = redirect_i | (discard_q != '0);
        fifo_push  = mem_rvalid_i & ~drop_resp & (~fifo_full | fifo_pop);
        push_entry = '{op: mem_rdata_i, pc: resp_pc_q};

        // outstanding counts live reads only; discard counts stale reads still in flight.
        out_inc = gnt_fire & ~stale_req_q;
        dis_inc = gnt_fire & stale_req_q;
        out_dec = mem_rvalid_i & (discard_q == '0);
        dis_dec = mem_rvalid_i & (discard_q != '0);

        req_d         = req_q;
        addr_d        = addr_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        stale_req_d   = stale_req_q;
        issue_pc      = fetch_pc_q;

        if (redirect_i) begin
            // Everything granted up to and including this cycle becomes stale.
            outstanding_d   = '0;
            discard_d       = CW'(SW'(discard_q) + SW'(outstanding_q)
                                  + SW'(gnt_fire) - SW'(mem_rvalid_i));
            stale_req_d     = req_q & ~mem_gnt_i;
            issue_pc        = word_align(target_i);
            fetch_pc_d      = issue_pc;
            resp_pc_d       = issue_pc;
            fifo_count_next = '0;
        end else begin
            outstanding_d   = outstanding_q + CW'(out_inc) - CW'(out_dec);
            discard_d       = discard_q + CW'(dis_inc) - CW'(dis_dec);
            stale_req_d     = stale_req_q & ~gnt_fire;
            if (fifo_push) resp_pc_d = resp_pc_q + XLEN'(WORD_BYTES);
            fifo_count_next = SW'(fifo_count) + SW'(fifo_push) - SW'(fifo_pop);
        end

        slots_used = SW'(outstanding_d) + SW'(discard_d) + fifo_count_next;
        credit_ok  = (slots_used < SW'(DEPTH));

        // A presented request holds address and valid until granted.
        if (!req_q || mem_gnt_i) begin
            req_d = credit_ok;
            if (credit_ok) begin
                addr_d     = issue_pc;
                fetch_pc_d = issue_pc + XLEN'(WORD_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q         <= 1'b0;
            addr_q        <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            stale_req_q   <= 1'b0;
        end else begin
            req_q         <= req_d;
            addr_q        <= addr_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            stale_req_q   <= stale_req_d;
        end
    end

    hs32_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_i),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign op_o       = fifo_empty ? '0 : head_entry.op;
    assign pc_o       = fifo_empty ? '0 : head_entry.pc;

endmodule
